// File: rtl/irq_priority_ctrl.sv
// irq_priority_ctrl: captures request events into a pending register, then
// presents the highest-index unmasked pending line through a valid/ack
// handshake. On ack, the serviced pending bit is cleared.
module irq_priority_ctrl #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3,
  parameter bit          EDGE  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  input  logic             irq_ack,
  output logic             irq_valid,
  output logic [IDX_W-1:0] irq_id,
  output logic [N-1:0]     pending
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       pending_q, pending_d;
  logic [N-1:0]       req_dly_q, req_dly_d;
  logic               irq_valid_q, irq_valid_d;
  logic [IDX_W-1:0]   irq_id_q, irq_id_d;

  logic [N-1:0]       set_vec;
  logic [N-1:0]       clr_vec;
  logic [N-1:0]       cand;
  logic [IDX_W-1:0]   cand_id;

  // Capture, priority selection and handshake next-state logic
  always_comb begin
    state_d     = state_q;
    irq_valid_d = irq_valid_q;
    irq_id_d    = irq_id_q;
    req_dly_d   = req;
    set_vec     = '0;
    clr_vec     = '0;
    cand_id     = '0;

    if (en) begin
      set_vec = EDGE ? (req & ~req_dly_q) : req;
    end

    // Ascending scan so the highest set index is the one left in cand_id
    cand = pending_q & ~mask;
    for (int unsigned k = 0; k < N; k++) begin
      if (cand[k]) cand_id = IDX_W'(k);
    end

    case (state_q)
      IDLE: begin
        if (en && (cand != '0)) begin
          irq_id_d    = cand_id;
          irq_valid_d = 1'b1;
          state_d     = PRESENT;
        end
      end
      PRESENT: begin
        if (irq_ack) begin
          clr_vec[irq_id_q] = 1'b1;
          irq_valid_d       = 1'b0;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new event on the line being cleared in the same cycle is kept
    pending_d = (pending_q & ~clr_vec) | set_vec;
  end

  // State, pending and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      req_dly_q   <= '0;
      irq_valid_q <= 1'b0;
      irq_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      req_dly_q   <= req_dly_d;
      irq_valid_q <= irq_valid_d;
      irq_id_q    <= irq_id_d;
    end
  end

  assign irq_valid = irq_valid_q;
  assign irq_id    = irq_id_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Testbench for irq_priority_ctrl: directed scenarios on edge- and level-mode
// instances plus a randomized run against a cycle-level reference model.
module tb_irq_priority_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       irq_ack = 1'b0;
  logic [7:0] req = '0;
  logic [7:0] mask = '0;

  logic       valid_e, valid_l;
  logic [2:0] id_e, id_l;
  logic [7:0] pend_e, pend_l;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model, index 1 = edge mode, index 0 = level mode
  int mp[2];
  int mid[2];
  bit mv[2];
  int mprev;

  irq_priority_ctrl #(.N(8), .IDX_W(3), .EDGE(1'b1)) dut_edge (
    .clk(clk), .rst(rst), .en(en), .req(req), .mask(mask), .irq_ack(irq_ack),
    .irq_valid(valid_e), .irq_id(id_e), .pending(pend_e)
  );

  irq_priority_ctrl #(.N(8), .IDX_W(3), .EDGE(1'b0)) dut_lvl (
    .clk(clk), .rst(rst), .en(en), .req(req), .mask(mask), .irq_ack(irq_ack),
    .irq_valid(valid_l), .irq_id(id_l), .pending(pend_l)
  );

  always #5 clk = ~clk;

  // Index of the most significant set bit (c > 0)
  function automatic int top_bit(input int c);
    return $clog2(c + 1) - 1;
  endfunction

  task automatic model_reset();
    for (int e = 0; e < 2; e++) begin
      mp[e] = 0; mid[e] = 0; mv[e] = 1'b0;
    end
    mprev = 0;
  endtask

  task automatic model_step();
    int r, s, clr, c;
    r = int'(req);
    for (int e = 0; e < 2; e++) begin
      s   = !en ? 0 : ((e == 1) ? (r & ~mprev) : r);
      clr = (mv[e] && irq_ack) ? (1 << mid[e]) : 0;
      c   = mp[e] & ~int'(mask) & 8'hFF;
      if (mv[e]) begin
        if (irq_ack) mv[e] = 1'b0;
      end else if (en && c != 0) begin
        mid[e] = top_bit(c);
        mv[e]  = 1'b1;
      end
      mp[e] = (mp[e] & ~clr) | s;
    end
    mprev = r;
  endtask

  // Drive inputs at the falling edge, advance one rising edge, return at the next falling edge
  task automatic tick(input logic [7:0] r, input logic [7:0] m, input logic e, input logic a);
    req = r; mask = m; en = e; irq_ack = a;
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++; if (valid_e !== 1'b0 || valid_l !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b/%b want 0", valid_e, valid_l); end
    n_tests++; if (id_e !== 3'd0 || id_l !== 3'd0) begin n_fail++; $display("FAIL reset_id: got %0d/%0d want 0", id_e, id_l); end
    n_tests++; if (pend_e !== 8'h00 || pend_l !== 8'h00) begin n_fail++; $display("FAIL reset_pend: got %h/%h want 00", pend_e, pend_l); end
    rst = 1'b0;
    model_reset();
    tick(8'h10, 8'h00, 1'b1, 1'b0);
    tick(8'h10, 8'h00, 1'b1, 1'b0);
    n_tests++; if (valid_e !== 1'b1 || id_e !== 3'd4) begin n_fail++; $display("FAIL reset_pre_present: got v=%b id=%0d want v=1 id=4", valid_e, id_e); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (valid_e !== 1'b0 || id_e !== 3'd0 || pend_e !== 8'h00) begin n_fail++; $display("FAIL reset_async: got v=%b id=%0d p=%h want 0/0/00", valid_e, id_e, pend_e); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick(8'h00, 8'h00, 1'b1, 1'b0);
    n_tests++; if (valid_e !== 1'b0 || pend_e !== 8'h00) begin n_fail++; $display("FAIL reset_idle_after: got v=%b p=%h want 0/00", valid_e, pend_e); end
    tick(8'h10, 8'h00, 1'b1, 1'b0);
    tick(8'h10, 8'h00, 1'b1, 1'b0);
    n_tests++; if (valid_e !== 1'b1 || id_e !== 3'd4) begin n_fail++; $display("FAIL reset_resume: got v=%b id=%0d want v=1 id=4", valid_e, id_e); end
    tick(8'h10, 8'h00, 1'b1, 1'b1);
    tick(8'h00, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_single();
    tick(8'h04, 8'h00, 1'b1, 1'b0);
    n_tests++; if (pend_e !== 8'h04 || valid_e !== 1'b0) begin n_fail++; $display("FAIL single_capture: got p=%h v=%b want 04/0", pend_e, valid_e); end
    tick(8'h04, 8'h00, 1'b1, 1'b0);
    n_tests++; if (valid_e !== 1'b1 || id_e !== 3'd2) begin n_fail++; $display("FAIL single_present: got v=%b id=%0d want 1/2", valid_e, id_e); end
    tick(8'h04, 8'h00, 1'b1, 1'b1);
    n_tests++; if (pend_e !== 8'h00 || valid_e !== 1'b0) begin n_fail++; $display("FAIL single_ack: got p=%h v=%b want 00/0", pend_e, valid_e); end
    tick(8'h00, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_priority();
    int ids[3] = '{6, 2, 0};
    tick(8'h45, 8'h00, 1'b1, 1'b0);
    n_tests++; if (pend_e !== 8'h45) begin n_fail++; $display("FAIL prio_capture: got %h want 45", pend_e); end
    for (int i = 0; i < 3; i++) begin
      tick(8'h45, 8'h00, 1'b1, 1'b0);
      n_tests++; if (valid_e !== 1'b1 || id_e !== 3'(ids[i])) begin n_fail++; $display("FAIL prio_order%0d: got v=%b id=%0d want 1/%0d", i, valid_e, id_e, ids[i]); end
      tick(8'h45, 8'h00, 1'b1, 1'b1);
      n_tests++; if (valid_e !== 1'b0) begin n_fail++; $display("FAIL prio_gap%0d: got v=%b want 0", i, valid_e); end
    end
    n_tests++; if (pend_e !== 8'h00) begin n_fail++; $display("FAIL prio_end: got %h want 00", pend_e); end
    tick(8'h00, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_mask();
    tick(8'h81, 8'h80, 1'b1, 1'b0);
    tick(8'h81, 8'h80, 1'b1, 1'b0);
    n_tests++; if (valid_e !== 1'b1 || id_e !== 3'd0) begin n_fail++; $display("FAIL mask_low: got v=%b id=%0d want 1/0", valid_e, id_e); end
    tick(8'h81, 8'h80, 1'b1, 1'b1);
    tick(8'h81, 8'h80, 1'b1, 1'b0);
    n_tests++; if (valid_e !== 1'b0 || pend_e !== 8'h80) begin n_fail++; $display("FAIL mask_retain: got v=%b p=%h want 0/80", valid_e, pend_e); end
    tick(8'h81, 8'h00, 1'b1, 1'b0);
    n_tests++; if (valid_e !== 1'b1 || id_e !== 3'd7) begin n_fail++; $display("FAIL mask_unmask: got v=%b id=%0d want 1/7", valid_e, id_e); end
    tick(8'h81, 8'h00, 1'b1, 1'b1);
    n_tests++; if (pend_e !== 8'h00) begin n_fail++; $display("FAIL mask_end: got %h want 00", pend_e); end
    tick(8'h00, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_collision();
    tick(8'h08, 8'h00, 1'b1, 1'b0);
    tick(8'h08, 8'h00, 1'b1, 1'b0);
    tick(8'h00, 8'h00, 1'b1, 1'b0);
    n_tests++; if (valid_e !== 1'b1 || id_e !== 3'd3) begin n_fail++; $display("FAIL coll_present: got v=%b id=%0d want 1/3", valid_e, id_e); end
    tick(8'h08, 8'h00, 1'b1, 1'b1);
    n_tests++; if (pend_e !== 8'h08 || valid_e !== 1'b0) begin n_fail++; $display("FAIL coll_setwins: got p=%h v=%b want 08/0", pend_e, valid_e); end
    tick(8'h08, 8'h00, 1'b1, 1'b0);
    n_tests++; if (valid_e !== 1'b1 || id_e !== 3'd3) begin n_fail++; $display("FAIL coll_represent: got v=%b id=%0d want 1/3", valid_e, id_e); end
    tick(8'h00, 8'h00, 1'b1, 1'b1);
    n_tests++; if (pend_e !== 8'h00) begin n_fail++; $display("FAIL coll_end: got %h want 00", pend_e); end
  endtask

  task automatic test_enable();
    tick(8'h00, 8'h00, 1'b0, 1'b0);
    tick(8'hFF, 8'h00, 1'b0, 1'b0);
    tick(8'hFF, 8'h00, 1'b0, 1'b0);
    n_tests++; if (pend_e !== 8'h00 || valid_e !== 1'b0) begin n_fail++; $display("FAIL en_off_capture: got p=%h v=%b want 00/0", pend_e, valid_e); end
    tick(8'h00, 8'h00, 1'b1, 1'b0);
    tick(8'h02, 8'h00, 1'b1, 1'b0);
    tick(8'h02, 8'h00, 1'b1, 1'b0);
    n_tests++; if (valid_e !== 1'b1 || id_e !== 3'd1) begin n_fail++; $display("FAIL en_present: got v=%b id=%0d want 1/1", valid_e, id_e); end
    tick(8'h02, 8'h00, 1'b0, 1'b1);
    n_tests++; if (valid_e !== 1'b0 || pend_e !== 8'h00) begin n_fail++; $display("FAIL en_off_ack: got v=%b p=%h want 0/00", valid_e, pend_e); end
    tick(8'h00, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_level();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    tick(8'h20, 8'h00, 1'b1, 1'b0);
    n_tests++; if (pend_l !== 8'h20) begin n_fail++; $display("FAIL lvl_capture: got %h want 20", pend_l); end
    tick(8'h20, 8'h00, 1'b1, 1'b0);
    n_tests++; if (valid_l !== 1'b1 || id_l !== 3'd5) begin n_fail++; $display("FAIL lvl_present: got v=%b id=%0d want 1/5", valid_l, id_l); end
    tick(8'h20, 8'h00, 1'b1, 1'b1);
    n_tests++; if (pend_l !== 8'h20 || valid_l !== 1'b0) begin n_fail++; $display("FAIL lvl_reset_bit: got p=%h v=%b want 20/0", pend_l, valid_l); end
    tick(8'h20, 8'h00, 1'b1, 1'b0);
    n_tests++; if (valid_l !== 1'b1 || id_l !== 3'd5) begin n_fail++; $display("FAIL lvl_represent: got v=%b id=%0d want 1/5", valid_l, id_l); end
    tick(8'h00, 8'h00, 1'b1, 1'b1);
    n_tests++; if (pend_l !== 8'h00) begin n_fail++; $display("FAIL lvl_end: got %h want 00", pend_l); end
  endtask

  task automatic test_random();
    logic [7:0] r, m;
    logic       e, a;
    r = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 600; i++) begin
      r = r ^ (8'($urandom) & 8'($urandom));
      m = ($urandom_range(0, 3) == 0) ? (8'($urandom) & 8'($urandom)) : 8'h00;
      e = ($urandom_range(0, 7) != 0);
      a = 1'($urandom_range(0, 1));
      tick(r, m, e, a);
      n_tests++; if (valid_e !== mv[1]) begin n_fail++; $display("FAIL rnd_valid_e @%0d: got %b want %b", i, valid_e, mv[1]); end
      n_tests++; if (id_e !== 3'(mid[1])) begin n_fail++; $display("FAIL rnd_id_e @%0d: got %0d want %0d", i, id_e, mid[1]); end
      n_tests++; if (pend_e !== 8'(mp[1])) begin n_fail++; $display("FAIL rnd_pend_e @%0d: got %h want %h", i, pend_e, 8'(mp[1])); end
      n_tests++; if (valid_l !== mv[0]) begin n_fail++; $display("FAIL rnd_valid_l @%0d: got %b want %b", i, valid_l, mv[0]); end
      n_tests++; if (id_l !== 3'(mid[0])) begin n_fail++; $display("FAIL rnd_id_l @%0d: got %0d want %0d", i, id_l, mid[0]); end
      n_tests++; if (pend_l !== 8'(mp[0])) begin n_fail++; $display("FAIL rnd_pend_l @%0d: got %h want %h", i, pend_l, 8'(mp[0])); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_collision();
    test_enable();
    test_level();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
